// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the CPU-side writer, the UART transmitter and uart_tx_fifo.
// The master side writes bytes and models the core's thre. The slave side is the FIFO.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  din;
    logic        wr;
    logic        flush;
    logic        clrovf;
    logic        thre;
    logic [7:0]  tx_d;
    logic        wrtx;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        irq;

    modport master (
        output din, wr, flush, clrovf, thre,
        input  tx_d, wrtx, count, full, empty, ovf, irq
    );

    modport slave (
        input  din, wr, flush, clrovf, thre,
        output tx_d, wrtx, count, full, empty, ovf, irq
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of UART_CORE.
// Software bursts bytes in, and the dequeue FSM feeds them to the core one at a time.
// After each load pulse, thre is ignored for HOLD cycles. This covers the core's lag in dropping it.
module uart_tx_fifo #(
    parameter int AW   = 4,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          resetb,
    uart_tx_fifo_if.slave bus
);
    localparam int              DEPTH   = 2 ** AW;
    localparam int              HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HLOAD   = HW'(HOLD - 1);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    state_t        state_r;
    logic [HW-1:0] hcnt_r;
    logic [7:0]    tx_d_r;
    logic          wrtx_r;
    logic          ovf_r;

    logic          full_s;
    logic          empty_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {(AW + 1){1'b0}});
    // A write into a full queue is dropped even when a pop frees a slot on the same edge.
    assign drop_s  = bus.wr & full_s;
    assign push_s  = bus.wr & ~full_s & ~bus.flush;
    // In the ISSUE cycle, a flush replaces the pop with the clear.
    assign pop_s   = (state_r == S_ISSUE) & ~bus.flush;

    // Byte storage: the write port only. The array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= bus.din;
        end
    end

    // Pointers and occupancy. Flush clears all of them and takes priority over push and pop.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else if (bus.flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag. A dropped write wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.clrovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Dequeue FSM with registered load pulse, data byte and hold counter.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_r <= S_IDLE;
            hcnt_r  <= {HW{1'b0}};
            tx_d_r  <= 8'h00;
            wrtx_r  <= 1'b0;
        end else if (bus.flush) begin
            state_r <= S_IDLE;
            hcnt_r  <= {HW{1'b0}};
            wrtx_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!empty_s && bus.thre) begin
                        state_r <= S_ISSUE;
                        tx_d_r  <= mem_r[rptr_r];
                        wrtx_r  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_WAIT;
                    hcnt_r  <= HLOAD;
                    wrtx_r  <= 1'b0;
                end
                S_WAIT: begin
                    if (hcnt_r != {HW{1'b0}}) begin
                        hcnt_r <= hcnt_r - HW'(1);
                    end else if (bus.thre) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    hcnt_r  <= {HW{1'b0}};
                    wrtx_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_d  = tx_d_r;
    assign bus.wrtx  = wrtx_r;
    assign bus.count = count_r;
    assign bus.full  = full_s;
    assign bus.empty = empty_s;
    assign bus.ovf   = ovf_r;
    assign bus.irq   = empty_s & bus.thre & (state_r == S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// A byte-queue reference model tracks contents, count and ovf.
// A small UART core model drives thre.
module tb_uart_tx_fifo;
    localparam int AW    = 4;
    localparam int HOLD  = 2;
    localparam int DEPTH = 16;
    localparam int LIM   = HOLD + 2;

    logic clk    = 1'b0;
    logic resetb = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.AW(AW)) bus ();

    uart_tx_fifo #(.AW(AW), .HOLD(HOLD)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    byte unsigned q[$];
    bit          ovf_m       = 1'b0;
    bit          pop_pending = 1'b0;
    int          cyc         = 0;
    int          last_pulse  = -1;
    int          pulses      = 0;
    int          stall       = 0;
    bit          core_auto   = 1'b0;
    int          core_len    = 170;
    int          busy        = 0;
    bit          load_seen   = 1'b0;
    logic [7:0]  last_tx     = 8'h00;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then sample and compare.
    task automatic tick();
        bit   drop;
        logic thre_edge;
        thre_edge = bus.thre;
        @(posedge clk);
        if (!resetb) begin
            q.delete();
            ovf_m      = 1'b0;
            last_pulse = -1;
        end else begin
            drop = bus.wr && (q.size() == DEPTH);
            if (drop) ovf_m = 1'b1;
            else if (bus.clrovf) ovf_m = 1'b0;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (pop_pending && q.size() > 0) void'(q.pop_front());
                if (bus.wr && !drop) q.push_back(bus.din);
            end
        end
        #1;
        cyc++;
        check_eq("count", bus.count, q.size());
        check_eq("full", bus.full, q.size() == DEPTH);
        check_eq("empty", bus.empty, q.size() == 0);
        check_eq("ovf", bus.ovf, ovf_m);
        if (bus.wrtx === 1'b1) begin
            pulses++;
            check_eq("pulse_nonempty", q.size() > 0, 1);
            if (q.size() > 0) check_eq("tx_data", bus.tx_d, q[0]);
            check_eq("thre_before_pulse", thre_edge, 1);
            if (last_pulse >= 0) check_eq("pulse_spacing", (cyc - last_pulse) >= HOLD + 2, 1);
            last_pulse = cyc;
            last_tx    = bus.tx_d;
        end
        pop_pending = (bus.wrtx === 1'b1) && resetb;
        if (q.size() > 0 && bus.thre && bus.wrtx !== 1'b1) stall++;
        else stall = 0;
        check_eq("stall", stall <= LIM, 1);
        if (core_auto) begin
            if (load_seen) begin
                bus.thre  = 1'b0;
                busy      = core_len;
                load_seen = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) bus.thre = 1'b1;
            end
            if (bus.wrtx === 1'b1) load_seen = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.wrtx !== 1'b1 && n < budget);
        check_eq("pulse_timeout", bus.wrtx, 1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr  = 1'b1;
        bus.din = b;
        tick();
        bus.wr  = 1'b0;
    endtask

    initial begin
        int         t1, t2, t3, pc, n;
        logic [7:0] exp_b [10];

        bus.din = 8'h00; bus.wr = 1'b0; bus.flush = 1'b0; bus.clrovf = 1'b0; bus.thre = 1'b1;

        // 1. Reset
        resetb = 1'b0;
        repeat (2) tick();
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_wrtx", bus.wrtx, 0);
        check_eq("rst_tx_d", bus.tx_d, 8'h00);
        check_eq("rst_ovf", bus.ovf, 0);
        check_eq("rst_irq", bus.irq, 1);
        resetb = 1'b1;
        tick();

        // 2. Single byte, latency and irq
        core_auto = 1'b1; core_len = 170;
        write_byte(8'h41);
        check_eq("lat_edge_n", bus.wrtx, 0);
        tick();
        check_eq("lat_pulse", bus.wrtx, 1);
        check_eq("lat_data", bus.tx_d, 8'h41);
        tick();
        check_eq("lat_after", bus.wrtx, 0);
        check_eq("single_count", bus.count, 0);
        n = 0;
        while (!bus.thre && n < 300) begin tick(); n++; end
        check_eq("thre_return", bus.thre, 1);
        #1;
        check_eq("irq_wait", bus.irq, 0);
        tick();
        check_eq("irq_idle", bus.irq, 1);

        // 3. Burst and order
        bus.wr = 1'b1; bus.din = 8'h41; tick();
        check_eq("burst_c1", bus.count, 1);
        bus.din = 8'h43; tick();
        check_eq("burst_c2", bus.count, 2);
        check_eq("burst_p1", bus.wrtx, 1);
        check_eq("burst_d1", bus.tx_d, 8'h41);
        t1 = cyc;
        bus.din = 8'h45; tick();
        bus.wr = 1'b0;
        check_eq("burst_c3", bus.count, 2);
        wait_pulse(400);
        t2 = cyc;
        check_eq("burst_d2", last_tx, 8'h43);
        tick();
        check_eq("burst_c4", bus.count, 1);
        wait_pulse(400);
        t3 = cyc;
        check_eq("burst_d3", last_tx, 8'h45);
        tick();
        check_eq("burst_c5", bus.count, 0);
        check_eq("burst_gap1", (t2 - t1) >= 170, 1);
        check_eq("burst_gap2", (t3 - t2) >= 170, 1);

        // 4. Overflow and wrap
        core_auto = 1'b0; busy = 0; load_seen = 1'b0; bus.thre = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            write_byte(8'(i));
            if (i == 15) begin
                check_eq("ovf_full16", bus.full, 1);
                check_eq("ovf_not_yet", bus.ovf, 0);
            end
        end
        check_eq("ovf_set", bus.ovf, 1);
        check_eq("ovf_count", bus.count, 16);
        bus.thre = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_pulse(20);
            check_eq("ovf_order", last_tx, i);
        end
        pc = pulses;
        repeat (20) tick();
        check_eq("ovf_no_10", pulses, pc);
        bus.clrovf = 1'b1; tick(); bus.clrovf = 1'b0;
        check_eq("ovf_clear", bus.ovf, 0);
        for (int r = 0; r < 2; r++) begin
            bus.thre = 1'b0;
            for (int k = 0; k < 10; k++) begin
                exp_b[k] = 8'($urandom);
                write_byte(exp_b[k]);
            end
            bus.thre = 1'b1;
            for (int k = 0; k < 10; k++) begin
                wait_pulse(20);
                check_eq("wrap_order", last_tx, exp_b[k]);
            end
        end
        repeat (6) tick();

        // 5. Simultaneous events
        bus.thre = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'($urandom));
        check_eq("sim_full", bus.full, 1);
        bus.thre = 1'b1;
        wait_pulse(6);
        bus.wr = 1'b1; bus.din = 8'hAA; tick(); bus.wr = 1'b0;
        check_eq("sim_count15", bus.count, 15);
        check_eq("sim_ovf", bus.ovf, 1);
        bus.thre = 1'b0;
        bus.clrovf = 1'b1; tick(); bus.clrovf = 1'b0;
        check_eq("sim_clr", bus.ovf, 0);
        write_byte(8'hBB);
        check_eq("sim_refill", bus.count, 16);
        bus.wr = 1'b1; bus.din = 8'hCC; bus.clrovf = 1'b1; tick();
        bus.wr = 1'b0; bus.clrovf = 1'b0;
        check_eq("sim_set_wins", bus.ovf, 1);
        bus.thre = 1'b1;
        repeat (16) wait_pulse(20);
        check_eq("sim_last", last_tx, 8'hBB);
        repeat (6) tick();
        check_eq("sim_drained", bus.count, 0);

        // 6. Flush during ISSUE, then reset during WAIT
        bus.thre = 1'b0;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
        bus.thre = 1'b1;
        wait_pulse(6);
        pc = pulses;
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        check_eq("flush_count", bus.count, 0);
        check_eq("flush_wrtx", bus.wrtx, 0);
        repeat (30) tick();
        check_eq("flush_nopulse", pulses, pc);
        bus.thre = 1'b0;
        write_byte(8'h71);
        write_byte(8'h72);
        core_auto = 1'b1; core_len = 50; busy = 0; load_seen = 1'b0; bus.thre = 1'b1;
        wait_pulse(6);
        tick();
        resetb = 1'b0;
        repeat (2) tick();
        check_eq("mrst_count", bus.count, 0);
        check_eq("mrst_empty", bus.empty, 1);
        check_eq("mrst_full", bus.full, 0);
        check_eq("mrst_wrtx", bus.wrtx, 0);
        check_eq("mrst_tx_d", bus.tx_d, 8'h00);
        check_eq("mrst_ovf", bus.ovf, 0);
        check_eq("mrst_irq", bus.irq, bus.thre);
        resetb = 1'b1;
        pc = pulses;
        repeat (80) tick();
        check_eq("mrst_nopulse", pulses, pc);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.wr     = 1'($urandom_range(0, 1));
            bus.din    = 8'($urandom);
            bus.flush  = ($urandom_range(0, 63) == 0);
            bus.clrovf = ($urandom_range(0, 15) == 0);
            core_len   = $urandom_range(1, 12);
            tick();
        end
        bus.wr = 1'b0; bus.flush = 1'b0; bus.clrovf = 1'b0;
        repeat (300) tick();
        check_eq("rand_drained", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
